// File: rtl/seq_1101_tx.sv
// seq_1101_tx: MSB-first serializer for the 1101 detection link,
// with a Mealy hit tracker and a saturating hit counter.
module seq_1101_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             expect_y,
  output logic             busy,
  input  logic             clear_count,
  output logic [7:0]       hit_count
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } st_e;

  typedef enum logic [1:0] {
    S0,
    S1,
    S11,
    S110
  } trk_e;

  st_e              state_q, state_d;
  trk_e             trk_q, trk_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       gap_q, gap_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic [7:0]       hit_q, hit_d;
  logic             last;
  logic             gap_done;
  logic             xfer;

  assign last     = (cnt_q == CW'(WIDTH - 1));
  assign gap_done = (gap_q == 4'(GAP_CYCLES - 1));
  assign xfer     = data_valid && data_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d = SHIFT;
          sh_d    = data_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          cnt_d = '0;
          gap_d = '0;
          if (xfer) begin
            sh_d = data_in;
          end else if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_ready = 1'b0;
    if (!reset) begin
      unique case (state_q)
        IDLE:    data_ready = 1'b1;
        SHIFT:   data_ready = last && (GAP_CYCLES == 0);
        default: data_ready = 1'b0;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  // x is launched from the next-cycle word image so it lands registered
  always_comb begin
    x_d  = 1'b0;
    xv_d = 1'b0;
    if (state_d == SHIFT) begin
      x_d  = sh_d[WIDTH-1];
      xv_d = 1'b1;
    end
  end

  always_comb begin
    trk_d = S0;
    unique case (trk_q)
      S0:      trk_d = x_q ? S1  : S0;
      S1:      trk_d = x_q ? S11 : S0;
      S11:     trk_d = x_q ? S11 : S110;
      S110:    trk_d = x_q ? S1  : S0;
      default: trk_d = S0;
    endcase
  end

  assign expect_y = (trk_q == S110) && x_q;

  always_comb begin
    hit_d = hit_q;
    if (clear_count) begin
      hit_d = '0;
    end else if (expect_y && (hit_q != 8'hFF)) begin
      hit_d = hit_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      gap_q <= '0;
      x_q   <= 1'b0;
      xv_q  <= 1'b0;
      trk_q <= S0;
      hit_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
      gap_q <= gap_d;
      x_q   <= x_d;
      xv_q  <= xv_d;
      trk_q <= trk_d;
      hit_q <= hit_d;
    end
  end

  assign x         = x_q;
  assign x_valid   = xv_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_seq_1101_tx.sv
// Bench for seq_1101_tx: a no-gap and a 3-cycle-gap instance, each
// checked every cycle against a queue/window model of the link.
module tb_seq_1101_tx;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  dv;
  logic [1:0]  clr;
  logic [1:0]  rdy;
  logic [1:0]  xo;
  logic [1:0]  xvo;
  logic [1:0]  yo;
  logic [1:0]  bo;
  logic [15:0] din;
  logic [15:0] hc;
  int          tests = 0;
  int          fails = 0;
  bit          started = 1'b0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int G = 3 * gi;
    bit [1:0]   q[$];
    logic [2:0] h = '0;
    int         mcnt = 0;

    seq_1101_tx #(.WIDTH(W), .GAP_CYCLES(G)) dut (
      .clk        (clk),
      .reset      (rst[gi]),
      .data_in    (din[gi*W +: W]),
      .data_valid (dv[gi]),
      .data_ready (rdy[gi]),
      .x          (xo[gi]),
      .x_valid    (xvo[gi]),
      .expect_y   (yo[gi]),
      .busy       (bo[gi]),
      .clear_count(clr[gi]),
      .hit_count  (hc[gi*8 +: 8])
    );

    // Queue holds the per-cycle {x, x_valid} still owed on the line;
    // a hit is simply the last four line bits reading 1101.
    always @(negedge clk) begin
      logic ex, exv, erdy, ey;
      if (started) begin
        ex  = 1'b0;
        exv = 1'b0;
        if (q.size() > 0) begin
          ex  = q[0][1];
          exv = q[0][0];
        end
        erdy = !rst[gi] && (q.size() <= ((G == 0) ? 1 : 0));
        ey   = ({h, ex} == 4'b1101);
        chk($sformatf("g%0d x", gi), xo[gi], ex);
        chk($sformatf("g%0d x_valid", gi), xvo[gi], exv);
        chk($sformatf("g%0d data_ready", gi), rdy[gi], erdy);
        chk($sformatf("g%0d busy", gi), bo[gi], q.size() > 0);
        chk($sformatf("g%0d expect_y", gi), yo[gi], ey);
        chk($sformatf("g%0d hit_count", gi), hc[gi*8 +: 8], 32'(mcnt));
        if (rst[gi]) begin
          q.delete();
          h    = '0;
          mcnt = 0;
        end else begin
          if (q.size() > 0) void'(q.pop_front());
          h = {h[1:0], ex};
          if (clr[gi]) mcnt = 0;
          else if (ey && mcnt < 255) mcnt++;
          if (dv[gi] && erdy) begin
            for (int b = W - 1; b >= 0; b--)
              q.push_back({din[gi*W + b], 1'b1});
            for (int k = 0; k < G; k++)
              q.push_back(2'b00);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // Offers w1 in an idle cycle (accepted at edge k), then records
  // cycles k+1..k+n, MSB of each vector being cycle k+1.
  task automatic send(input int i, input logic [7:0] w1, input logic [7:0] w2,
                      input int drop, input int n, input int rst_at,
                      input int clr_at, input int mark,
                      output logic [31:0] xs, output logic [31:0] xvs,
                      output logic [31:0] ys, output logic [31:0] rs,
                      output logic [31:0] bs, output logic [7:0] hm);
    xs  = '0;
    xvs = '0;
    ys  = '0;
    rs  = '0;
    bs  = '0;
    hm  = '0;
    cyc();
    dv[i]          = 1'b1;
    din[i*W +: W]  = w1;
    for (int c = 1; c <= n; c++) begin
      cyc();
      if (c == 1) din[i*W +: W] = w2;
      if (c == drop) dv[i] = 1'b0;
      rst[i] = (c == rst_at);
      clr[i] = (c == clr_at);
      @(negedge clk);
      xs  = {xs[30:0], xo[i]};
      xvs = {xvs[30:0], xvo[i]};
      ys  = {ys[30:0], yo[i]};
      rs  = {rs[30:0], rdy[i]};
      bs  = {bs[30:0], bo[i]};
      if (c == mark) hm = hc[i*8 +: 8];
    end
  endtask

  initial begin
    logic [31:0] xs, xvs, ys, rs, bs;
    logic [7:0]  hm;
    rst = 2'b11;
    dv  = 2'b00;
    clr = 2'b00;
    din = '0;
    @(posedge clk);
    #1;
    started = 1'b1;
    @(negedge clk);
    chk("reset data_ready", rdy, 32'h0);
    chk("reset x/x_valid", {xvo, xo}, 32'h0);
    chk("reset busy", bo, 32'h0);
    chk("reset hit_count", hc, 32'h0);
    cyc();
    rst = 2'b00;
    @(negedge clk);
    chk("post-reset data_ready", rdy, 32'h3);

    // single word with overlapping hits
    send(0, 8'hDB, 8'h00, 1, 9, 0, 0, 9, xs, xvs, ys, rs, bs, hm);
    chk("single x", xs, 32'h1B6);
    chk("single x_valid", xvs, 32'h1FE);
    chk("single expect_y", ys, 32'h024);
    chk("single data_ready", rs, 32'h003);
    chk("single hit_count", hm, 32'd2);
    chk("single model count", 32'(g[0].mcnt), 32'd2);

    // back-to-back words, no bubble
    send(0, 8'hD0, 8'h0D, 9, 17, 0, 0, 17, xs, xvs, ys, rs, bs, hm);
    chk("b2b x", xs, 32'h1A01A);
    chk("b2b x_valid", xvs, 32'h1FFFE);
    chk("b2b expect_y", ys, 32'h02002);
    chk("b2b data_ready", rs, 32'h0203);
    chk("b2b hit_count", hm, 32'd4);

    // reset abandons a word
    send(0, 8'hDD, 8'h00, 1, 12, 3, 0, 4, xs, xvs, ys, rs, bs, hm);
    chk("rst x", xs, 32'hC00);
    chk("rst x_valid", xvs, 32'hE00);
    chk("rst busy", bs, 32'hE00);
    chk("rst data_ready", rs, 32'h1FF);
    chk("rst hit_count", hm, 32'd0);
    send(0, 8'hD0, 8'h00, 1, 9, 0, 0, 9, xs, xvs, ys, rs, bs, hm);
    chk("after rst expect_y", ys, 32'h020);
    chk("after rst hit_count", hm, 32'd1);

    // saturation over 128 words of DD
    send(0, 8'hDD, 8'hDD, 1017, 1025, 0, 0, 1025, xs, xvs, ys, rs, bs, hm);
    chk("sat hit_count", hm, 32'd255);
    chk("sat model count", 32'(g[0].mcnt), 32'd255);
    chk("sat x_valid tail", xvs, 32'hFFFFFFFE);
    chk("sat data_ready tail", rs, 32'h02020203);

    // clear wins over a simultaneous hit
    send(0, 8'hDD, 8'h00, 1, 9, 0, 4, 5, xs, xvs, ys, rs, bs, hm);
    chk("clear hit_count", hm, 32'd0);
    chk("clear then hit", hc[7:0], 32'd1);

    // gap instance: gap breaks a 1101 spanning two words
    send(1, 8'h06, 8'h80, 13, 21, 0, 0, 21, xs, xvs, ys, rs, bs, hm);
    chk("gap x", xs, 32'h0C100);
    chk("gap x_valid", xvs, 32'h1FE1FE);
    chk("gap data_ready", rs, 32'h200);
    chk("gap busy", bs, 32'h1FFDFF);
    chk("gap expect_y", ys, 32'h0);
    chk("gap hit_count", hm, 32'd0);
    idle(3);
    send(1, 8'hD0, 8'h00, 1, 12, 0, 0, 12, xs, xvs, ys, rs, bs, hm);
    chk("gap single expect_y", ys, 32'h100);
    chk("gap single data_ready", rs, 32'h001);
    chk("gap single hit_count", hm, 32'd1);

    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
